button_cond: RTL and testbench

BUTTON_COND -- requirements
Module: button_cond

---
 rtl/button_cond.sv | 139 +++++++++++++
 tb/tb_button_cond.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_cond.sv
// ---------------------------------------------------------------------------
// button_cond
//
// Conditions a mechanical push-button for use by a downstream controller:
// synchronises the raw pin, debounces it, and derives a press pulse, a
// sticky request (cleared by an acknowledge) and a long-press pulse.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level (>= 2)
//   LONG_CYCLES      pressed duration, in cycles, that flags a long press
//                    (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW       1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//
// Ports
//   clk_i        in   system clock, all state on its rising edge
//   rst          in   asynchronous reset, active low
//   button_raw   in   unsynchronised push-button pin
//   ack_i        in   request acknowledge from the downstream controller
//   button       out  debounced pressed level, active high
//   press_pulse  out  one-cycle pulse per accepted press
//   req          out  sticky request, held until acknowledged
//   long_pulse   out  one-cycle pulse when a press lasts LONG_CYCLES
// ---------------------------------------------------------------------------
module button_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst,
  input  logic button_raw,
  input  logic ack_i,
  output logic button,
  output logic press_pulse,
  output logic req,
  output logic long_pulse
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  // Raw pin level that means "not pressed"; the synchroniser resets to it so
  // that leaving reset never looks like a press edge.
  localparam logic RAW_IDLE = ACTIVE_LOW;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              button_q, button_d;
  logic              button_prev_q, button_prev_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_pulse_q, press_pulse_d;
  logic              req_q, req_d;
  logic              long_pulse_q, long_pulse_d;

  logic              level;
  logic              rise;

  always_comb begin
    sync1_d       = button_raw;
    sync2_d       = sync1_q;
    button_d      = button_q;
    button_prev_d = button_q;
    db_cnt_d      = '0;
    hold_cnt_d    = '0;
    req_d         = req_q;

    // Normalised, synchronised pressed level (1 = pressed).
    level = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce: count cycles of disagreement; accept on the last one.
    // The counter clears on any agreement and after acceptance, so it
    // never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    if (level != button_q) begin
      if (db_cnt_q == DB_LAST) begin
        button_d = level;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    rise          = button_q & ~button_prev_q;
    press_pulse_d = rise;

    // A new press takes priority over an acknowledge arriving in the same
    // cycle the press becomes visible, so that press is never lost.
    if (rise) begin
      req_d = 1'b1;
    end else if (ack_i && !press_pulse_q) begin
      req_d = 1'b0;
    end

    // Hold counter saturates at LONG_CYCLES, which is what limits the long
    // pulse to once per press.
    if (button_q) begin
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end

    long_pulse_d = button_q && (hold_cnt_q == HOLD_PRE);
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      sync1_q       <= RAW_IDLE;
      sync2_q       <= RAW_IDLE;
      button_q      <= 1'b0;
      button_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      press_pulse_q <= 1'b0;
      req_q         <= 1'b0;
      long_pulse_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      button_q      <= button_d;
      button_prev_q <= button_prev_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      press_pulse_q <= press_pulse_d;
      req_q         <= req_d;
      long_pulse_q  <= long_pulse_d;
    end
  end

  assign button      = button_q;
  assign press_pulse = press_pulse_q;
  assign req         = req_q;
  assign long_pulse  = long_pulse_q;

endmodule

// File: tb/tb_button_cond.sv
// ---------------------------------------------------------------------------
// tb_button_cond
//
// Directed bench for button_cond with DEBOUNCE_CYCLES=4, LONG_CYCLES=10,
// ACTIVE_LOW=1. Expected output vectors {button, press_pulse, req,
// long_pulse} are queued against absolute cycle numbers when stimulus is
// applied and compared on the falling edge of the matching cycle.
// ---------------------------------------------------------------------------
module tb_button_cond;

  logic clk_i = 1'b0;
  logic rst;
  logic button_raw;
  logic ack_i;
  logic button;
  logic press_pulse;
  logic req;
  logic long_pulse;
  logic [3:0] outs;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         when;
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  button_cond #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .button_raw (button_raw),
    .ack_i      (ack_i),
    .button     (button),
    .press_pulse(press_pulse),
    .req        (req),
    .long_pulse (long_pulse)
  );

  assign outs = {button, press_pulse, req, long_pulse};

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Queue an expected output vector for an absolute cycle, kept sorted.
  function automatic void expect_at(int when, string tag, logic [3:0] v);
    exp_t e;
    int   i;
    e.when = when;
    e.tag  = tag;
    e.v    = v;
    i = 0;
    while (i < exp_q.size() && exp_q[i].when <= when) i++;
    exp_q.insert(i, e);
  endfunction

  // Scoreboard: pop every expectation due this cycle and compare.
  always @(negedge clk_i) begin
    while (exp_q.size() > 0 && exp_q[0].when <= cyc) begin
      cur = exp_q.pop_front();
      checks++;
      assert (cur.when == cyc && outs === cur.v) else begin
        errors++;
        $error("FAIL %s cycle=%0d observed={btn,pp,req,lp}=%b expected=%b",
               cur.tag, cyc, outs, cur.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int t;

  initial begin
    rst        = 1'b1;
    button_raw = 1'b1;
    ack_i      = 1'b0;

    // Reset must act with no clock edge.
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (outs === 4'b0000) else begin
      errors++;
      $error("FAIL reset_async observed=%b expected=%b", outs, 4'b0000);
    end

    repeat (3) tick();
    rst = 1'b1;
    expect_at(cyc + 2, "idle", 4'b0000);
    repeat (3) tick();

    // Clean press, then long press with continued hold.
    t = cyc;
    button_raw = 1'b0;
    expect_at(t + 5,  "press_lat_m1", 4'b0000);
    expect_at(t + 6,  "press_btn",    4'b1000);
    expect_at(t + 7,  "press_pulse",  4'b1110);
    expect_at(t + 8,  "press_pulse1", 4'b1010);
    expect_at(t + 15, "long_pre",     4'b1010);
    expect_at(t + 16, "long_pulse",   4'b1011);
    expect_at(t + 17, "long_once",    4'b1010);
    expect_at(t + 25, "long_nomore",  4'b1010);
    repeat (26) tick();

    // Acknowledge clears req the next cycle.
    ack_i = 1'b1;
    expect_at(cyc,     "pre_ack",   4'b1010);
    expect_at(cyc + 1, "ack_clear", 4'b1000);
    tick();
    ack_i = 1'b0;
    tick();

    // Acknowledge while req is low does nothing.
    ack_i = 1'b1;
    expect_at(cyc + 1, "ack_noreq", 4'b1000);
    tick();
    ack_i = 1'b0;
    tick();

    // Release: button falls after the same latency, no pulse.
    t = cyc;
    button_raw = 1'b1;
    expect_at(t + 5, "rel_lat_m1",   4'b1000);
    expect_at(t + 6, "rel_btn",      4'b0000);
    expect_at(t + 7, "rel_no_pulse", 4'b0000);
    repeat (10) tick();

    // Bounce: low 3, high 1, then low and held.
    button_raw = 1'b0;
    repeat (3) tick();
    button_raw = 1'b1;
    tick();
    button_raw = 1'b0;
    t = cyc;
    expect_at(t + 2, "glitch_reject", 4'b0000);
    expect_at(t + 5, "bounce_m1",     4'b0000);
    expect_at(t + 6, "bounce_btn",    4'b1000);
    expect_at(t + 7, "bounce_pulse",  4'b1110);
    repeat (7) tick();

    // Acknowledge coinciding with press_pulse: req stays set.
    ack_i = 1'b1;
    expect_at(cyc + 1, "ack_vs_press", 4'b1010);
    tick();
    ack_i = 1'b0;

    // Release after 8 pressed cycles: no long pulse.
    button_raw = 1'b1;
    expect_at(cyc + 5,  "short_hold",    4'b1010);
    expect_at(cyc + 6,  "short_rel",     4'b0010);
    expect_at(cyc + 8,  "short_no_long", 4'b0010);
    expect_at(cyc + 12, "short_quiet",   4'b0010);
    repeat (14) tick();

    // Reset while the debounce counter is at 2.
    t = cyc;
    button_raw = 1'b0;
    expect_at(t + 3, "pre_reset", 4'b0010);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    checks++;
    assert (outs === 4'b0000) else begin
      errors++;
      $error("FAIL reset_mid observed=%b expected=%b", outs, 4'b0000);
    end
    repeat (2) tick();
    rst = 1'b1;
    t = cyc;
    expect_at(t + 5,  "rst_lat_m1",   4'b0000);
    expect_at(t + 6,  "rst_btn",      4'b1000);
    expect_at(t + 7,  "rst_pulse",    4'b1110);
    expect_at(t + 15, "rst_long_pre", 4'b1010);
    expect_at(t + 16, "rst_long",     4'b1011);
    expect_at(t + 17, "rst_long_one", 4'b1010);
    expect_at(t + 24, "rst_hold",     4'b1010);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s timeout observed=none expected=%b", cur.tag, cur.v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
